// File: rtl/msm_pkg.sv
// Shared MSM datapath types and constants: point record layout and result-buffer defaults.
package msm_pkg;

   localparam int WIDTH_ID   = 2;
   localparam int WIDTH_DATA = 384;
   localparam int POINT_W    = WIDTH_ID + 3 * WIDTH_DATA;

   // Projective point as it leaves the point adder, tagged with its bucket id.
   typedef struct packed {
      logic [WIDTH_ID-1:0]   id;
      logic [WIDTH_DATA-1:0] x;
      logic [WIDTH_DATA-1:0] y;
      logic [WIDTH_DATA-1:0] z;
   } point_t;

   // An all-zero point is treated as "no operand" by the operand muxes.
   localparam point_t BUBBLE = '0;

   localparam int RB_DEPTH    = 16;
   localparam int RB_AFULL_TH = 12;

endpackage

// File: rtl/msm_result_buffer_if.sv
// Result-buffer port bundle: PADD write side, controller pop side, and status.
interface msm_result_buffer_if
   import msm_pkg::*;
#(
   parameter int DEPTH = RB_DEPTH
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          clr;
   logic          wr_en;
   point_t        wr_data;
   logic          rd_one;
   logic          rd_two;
   point_t        rd_data_a;
   point_t        rd_data_b;
   logic          rd_valid_a;
   logic          rd_valid_b;
   logic [CW-1:0] count;
   logic          full;
   logic          almost_full;
   logic          ovf_err;
   logic          udf_err;

   // Controller / PADD side.
   modport master (
      output clr, wr_en, wr_data, rd_one, rd_two,
      input  rd_data_a, rd_data_b, rd_valid_a, rd_valid_b,
             count, full, almost_full, ovf_err, udf_err
   );

   // Buffer side.
   modport slave (
      input  clr, wr_en, wr_data, rd_one, rd_two,
      output rd_data_a, rd_data_b, rd_valid_a, rd_valid_b,
             count, full, almost_full, ovf_err, udf_err
   );

endinterface

// File: rtl/msm_rb_mem.sv
// DEPTH x W storage with one synchronous write port and two asynchronous read ports.
// Isolated so it can be replaced by a 2R1W RAM macro.
module msm_rb_mem #(
   parameter int DEPTH = 16,
   parameter int W     = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr_a,
   input  logic [AW-1:0] raddr_b,
   output logic [W-1:0]  rdata_a,
   output logic [W-1:0]  rdata_b
);

   logic [W-1:0] mem [DEPTH];

   // Write port.
   // NOTE: storage has no reset; validity is tracked by the pointers and count, so stale data is never exposed.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/msm_result_buffer.sv
// Result buffer between PADD output and MSM operand muxes: FIFO of PADD results with
// the two oldest entries visible at once, 1- or 2-entry pops, and sticky error flags.
module msm_result_buffer
   import msm_pkg::*;
#(
   parameter int DEPTH    = RB_DEPTH,
   parameter int AFULL_TH = RB_AFULL_TH
) (
   input  logic                clk,
   input  logic                rst_n,
   msm_result_buffer_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          ovf_q, udf_q;

   logic [1:0]    n_req;
   logic          pop_ok;
   logic [CW-1:0] n_legal;
   logic          wr_acc;
   logic [CW-1:0] count_nxt;
   point_t        mem_a, mem_b;

   // Decide pop amount, pop legality and write acceptance for this cycle.
   // NOTE: every combinational output gets a default first so no latch can be inferred.
   always_comb begin
      n_req     = 2'd0;
      pop_ok    = 1'b1;
      n_legal   = '0;
      wr_acc    = 1'b0;
      count_nxt = count_q;
      if (bus.rd_two)      n_req = 2'd2;
      else if (bus.rd_one) n_req = 2'd1;
      pop_ok  = CW'(n_req) <= count_q;
      n_legal = pop_ok ? CW'(n_req) : '0;
      // A same-cycle pop frees space, so a write at full with a legal pop still lands.
      wr_acc    = bus.wr_en && ((count_q - n_legal) < CW'(DEPTH));
      count_nxt = count_q + CW'(wr_acc) - n_legal;
   end

   // Pointer, occupancy and sticky-flag state; clr flushes but keeps the error flags.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else if (bus.clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
         rd_ptr_q <= rd_ptr_q + AW'(n_legal);
         count_q  <= count_nxt;
         if (bus.wr_en && !wr_acc) ovf_q <= 1'b1;
         if (!pop_ok)              udf_q <= 1'b1;
      end
   end

   msm_rb_mem #(
      .DEPTH (DEPTH),
      .W     (POINT_W)
   ) u_mem (
      .clk     (clk),
      .we      (wr_acc && !bus.clr),
      .waddr   (wr_ptr_q),
      .wdata   (bus.wr_data),
      .raddr_a (rd_ptr_q),
      .raddr_b (rd_ptr_q + AW'(1)),
      .rdata_a (mem_a),
      .rdata_b (mem_b)
   );

   assign bus.rd_valid_a  = count_q >= CW'(1);
   assign bus.rd_valid_b  = count_q >= CW'(2);
   assign bus.rd_data_a   = bus.rd_valid_a ? mem_a : BUBBLE;
   assign bus.rd_data_b   = bus.rd_valid_b ? mem_b : BUBBLE;
   assign bus.count       = count_q;
   assign bus.full        = count_q == CW'(DEPTH);
   assign bus.almost_full = count_q >= CW'(AFULL_TH);
   assign bus.ovf_err     = ovf_q;
   assign bus.udf_err     = udf_q;

endmodule

// File: tb/tb_msm_result_buffer.sv
// Self-checking bench for msm_result_buffer: table of single-cycle vectors plus
// hand-written fill, full-with-pop, wrap, async-reset and flush sequences.
module tb_msm_result_buffer;
   import msm_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   msm_result_buffer_if #(.DEPTH(16)) bus ();

   msm_result_buffer #(
      .DEPTH    (16),
      .AFULL_TH (12)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       wr;
      logic [7:0] key;
      logic       one;
      logic       two;
      logic       clr;
      int         cnt;
      logic [7:0] ka;
      logic [7:0] kb;
      logic       ovf;
      logic       udf;
   } vec_t;

   vec_t tbl [12];

   // Distinct, recognisable point for a non-zero key; key 0 stands for BUBBLE.
   function automatic point_t mk(input logic [7:0] key);
      point_t p;
      if (key == 8'h00) return BUBBLE;
      p.id = key[1:0];
      p.x  = {48{key}};
      p.y  = ~{48{key}};
      p.z  = {48{key}} ^ {12{32'hdeadbeef}};
      return p;
   endfunction

   task automatic check_v(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_p(input string name, input point_t act, input point_t exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got id=%h x[31:0]=%h expected id=%h x[31:0]=%h",
                  name, act.id, act.x[31:0], exp.id, exp.x[31:0]);
      end
   endtask

   task automatic idle();
      bus.clr     = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_data = BUBBLE;
      bus.rd_one  = 1'b0;
      bus.rd_two  = 1'b0;
   endtask

   // One clock edge; returns at the following falling edge, where outputs are stable.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic push(input logic [7:0] key);
      bus.wr_en   = 1'b1;
      bus.wr_data = mk(key);
      cyc();
      idle();
   endtask

   initial begin
      logic [7:0] q [$];
      logic [7:0] ek;
      logic       pop;
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b1;
      idle();

      //             wr  key    one  two  clr cnt  ka     kb     ovf  udf
      tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1, 8'h11, 8'h00, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 2, 8'h11, 8'h22, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 8'h22, 8'h00, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1, 8'h22, 8'h00, 1'b0, 1'b1};
      tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h00, 8'h00, 1'b0, 1'b1};
      tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h00, 8'h00, 1'b0, 1'b1};
      tbl[6]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1, 8'h33, 8'h00, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 2, 8'h33, 8'h44, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1, 8'h55, 8'h00, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 2, 8'h55, 8'h66, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 0, 8'h00, 8'h00, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1, 8'h77, 8'h00, 1'b0, 1'b1};

      // Reset state.
      do_reset();
      check_v("rst_count", int'(bus.count), 0);
      check_v("rst_valid_a", int'(bus.rd_valid_a), 0);
      check_v("rst_valid_b", int'(bus.rd_valid_b), 0);
      check_v("rst_full", int'(bus.full), 0);
      check_v("rst_afull", int'(bus.almost_full), 0);
      check_v("rst_ovf", int'(bus.ovf_err), 0);
      check_v("rst_udf", int'(bus.udf_err), 0);
      check_p("rst_data_a", bus.rd_data_a, BUBBLE);
      check_p("rst_data_b", bus.rd_data_b, BUBBLE);

      // Table-driven single-cycle vectors.
      for (int i = 0; i < 12; i++) begin
         bus.wr_en   = tbl[i].wr;
         bus.wr_data = mk(tbl[i].key);
         bus.rd_one  = tbl[i].one;
         bus.rd_two  = tbl[i].two;
         bus.clr     = tbl[i].clr;
         cyc();
         idle();
         check_v($sformatf("vec%0d_count", i), int'(bus.count), tbl[i].cnt);
         check_v($sformatf("vec%0d_valid_a", i), int'(bus.rd_valid_a), int'(tbl[i].ka != 8'h00));
         check_v($sformatf("vec%0d_valid_b", i), int'(bus.rd_valid_b), int'(tbl[i].kb != 8'h00));
         check_p($sformatf("vec%0d_data_a", i), bus.rd_data_a, mk(tbl[i].ka));
         check_p($sformatf("vec%0d_data_b", i), bus.rd_data_b, mk(tbl[i].kb));
         check_v($sformatf("vec%0d_ovf", i), int'(bus.ovf_err), int'(tbl[i].ovf));
         check_v($sformatf("vec%0d_udf", i), int'(bus.udf_err), int'(tbl[i].udf));
      end

      // Fill to full, then one write too many.
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         push(8'h80 + 8'(i));
         check_v($sformatf("fill%0d_count", i), int'(bus.count), i);
         check_v($sformatf("fill%0d_afull", i), int'(bus.almost_full), int'(i >= 12));
         check_v($sformatf("fill%0d_full", i), int'(bus.full), int'(i == 16));
      end
      push(8'hA0);
      check_v("ovf_count", int'(bus.count), 16);
      check_v("ovf_flag", int'(bus.ovf_err), 1);
      check_p("ovf_head", bus.rd_data_a, mk(8'h81));
      check_v("ovf_udf", int'(bus.udf_err), 0);

      // Full with write and rd_two in the same cycle.
      do_reset();
      for (int i = 1; i <= 16; i++) push(8'(i));
      bus.wr_en   = 1'b1;
      bus.wr_data = mk(8'h99);
      bus.rd_two  = 1'b1;
      cyc();
      idle();
      check_v("fullpop_count", int'(bus.count), 15);
      check_v("fullpop_ovf", int'(bus.ovf_err), 0);
      check_v("fullpop_full", int'(bus.full), 0);
      check_p("fullpop_a", bus.rd_data_a, mk(8'h03));
      check_p("fullpop_b", bus.rd_data_b, mk(8'h04));
      // Drain one at a time; the new entry must come out last.
      for (int k = 0; k < 15; k++) begin
         ek = (k < 14) ? 8'(3 + k) : 8'h99;
         check_p($sformatf("drain%0d_a", k), bus.rd_data_a, mk(ek));
         bus.rd_one = 1'b1;
         cyc();
         idle();
      end
      check_v("drain_count", int'(bus.count), 0);
      check_p("drain_empty_a", bus.rd_data_a, BUBBLE);

      // Interleaved writes and pops across the pointer wrap, against a reference queue.
      q.delete();
      for (int i = 0; i < 20; i++) begin
         pop         = q.size() >= 3;
         bus.wr_en   = 1'b1;
         bus.wr_data = mk(8'h40 + 8'(i));
         bus.rd_one  = pop;
         cyc();
         idle();
         if (pop) void'(q.pop_front());
         q.push_back(8'h40 + 8'(i));
         check_v($sformatf("wrap%0d_count", i), int'(bus.count), q.size());
         check_p($sformatf("wrap%0d_a", i), bus.rd_data_a, mk(q[0]));
         check_p($sformatf("wrap%0d_b", i), bus.rd_data_b, (q.size() >= 2) ? mk(q[1]) : BUBBLE);
      end
      while (q.size() > 0) begin
         bus.rd_one = 1'b1;
         cyc();
         idle();
         void'(q.pop_front());
         check_p("wrapdrain_a", bus.rd_data_a, (q.size() >= 1) ? mk(q[0]) : BUBBLE);
         check_p("wrapdrain_b", bus.rd_data_b, (q.size() >= 2) ? mk(q[1]) : BUBBLE);
      end

      // Asynchronous reset in the middle of a cycle.
      do_reset();
      for (int i = 1; i <= 5; i++) push(8'h60 + 8'(i));
      check_v("pre_arst_count", int'(bus.count), 5);
      #2 rst_n = 1'b0;
      #1;
      check_v("arst_count", int'(bus.count), 0);
      check_v("arst_valid_a", int'(bus.rd_valid_a), 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      check_v("post_arst_count", int'(bus.count), 0);
      check_p("post_arst_a", bus.rd_data_a, BUBBLE);

      // Flush keeps the sticky error flags.
      push(8'h71);
      bus.rd_two = 1'b1;
      cyc();
      idle();
      check_v("clr_pre_udf", int'(bus.udf_err), 1);
      for (int i = 2; i <= 5; i++) push(8'h70 + 8'(i));
      check_v("clr_pre_count", int'(bus.count), 5);
      bus.clr = 1'b1;
      cyc();
      idle();
      check_v("clr_count", int'(bus.count), 0);
      check_v("clr_valid_a", int'(bus.rd_valid_a), 0);
      check_v("clr_udf_kept", int'(bus.udf_err), 1);
      check_v("clr_ovf_kept", int'(bus.ovf_err), 0);
      push(8'h7F);
      check_p("clr_new_head", bus.rd_data_a, mk(8'h7F));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
